// File: rtl/mmio_uart_tx.sv
//==============================================================================
// Module   : mmio_uart_tx
// Purpose  : Memory-mapped serial transmitter. It sits on the CPU data bus
//            next to DataMemory and decodes a 16-byte register window. Bytes
//            written to TXDATA are queued in a FIFO and sent out as 8N1
//            frames (8E1 when the parity option is built in).
//
// Ports    : InputClk   - clock (the same inverted CPU clock that DataMemory gets)
//            rst        - synchronous, active-high reset
//            MemReadEn  - bus read strobe (ControlBus[1])
//            MemWriteEn - bus write strobe (ControlBus[2])
//            AddressBus - 32-bit byte address
//            DataIn     - 32-bit write data
//            DataOut    - 32-bit read data; 0 unless Hit and MemReadEn
//            Hit        - combinational window decode, qualified by a strobe
//            TxOut      - serial line, idles high
//            TxBusy     - high while a frame is being shifted
//
// Registers: 0x0 TXDATA (W)   push DataIn[7:0]; reads return 0
//            0x4 STATUS (R)   {count[15:8], ovf[3], busy[2], empty[1], full[0]}
//            0x8 DIV    (R/W) clocks per bit; a value of 0 runs as 1
//            0xC CTRL   (R/W) bit0 enable, bit1 flush (W1), bit2 clear ovf (W1)
//
// Options  : MMIO_UART_PARITY_EN - when defined, an even-parity bit is sent
//            between the last data bit and the stop bit.
//
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          DIV_WIDTH   = 16,
   parameter int          DEFAULT_DIV = 16
) (
   input  logic        InputClk,
   input  logic        rst,
   input  logic        MemReadEn,
   input  logic        MemWriteEn,
   input  logic [31:0] AddressBus,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        Hit,
   output logic        TxOut,
   output logic        TxBusy
);

   //---------------------------------------------------------------------------
   // Derived widths and constants
   //---------------------------------------------------------------------------
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

   localparam logic [1:0] SEL_TXDATA = 2'd0;
   localparam logic [1:0] SEL_STATUS = 2'd1;
   localparam logic [1:0] SEL_DIV    = 2'd2;
   localparam logic [1:0] SEL_CTRL   = 2'd3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef MMIO_UART_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [7:0]           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic [DIV_WIDTH-1:0] div;
   logic                 enable;
   logic                 overflow;

   logic [2:0]           state;
   logic [DIV_WIDTH-1:0] bit_cnt;
   logic [2:0]           bit_idx;
   logic [7:0]           shift;
   logic                 tx_out;
`ifdef MMIO_UART_PARITY_EN
   logic                 parity;
`endif

   //---------------------------------------------------------------------------
   // Bus decode
   //---------------------------------------------------------------------------
   logic       in_window;
   logic [1:0] sel;
   logic       wr_hit;
   logic       push_req;
   logic       div_we;
   logic       ctrl_we;
   logic       flush;
   logic       clear_ovf;

   assign in_window = (AddressBus[31:4] == BASE_ADDR[31:4]);
   assign Hit       = in_window && (MemReadEn || MemWriteEn);
   assign sel       = AddressBus[3:2];
   assign wr_hit    = Hit && MemWriteEn;

   assign push_req  = wr_hit && (sel == SEL_TXDATA);
   assign div_we    = wr_hit && (sel == SEL_DIV);
   assign ctrl_we   = wr_hit && (sel == SEL_CTRL);
   assign flush     = ctrl_we && DataIn[1];
   assign clear_ovf = ctrl_we && DataIn[2];

   // The low address bits and the upper write-data bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{AddressBus[1:0], DataIn};

   //---------------------------------------------------------------------------
   // FIFO status and handshake
   //---------------------------------------------------------------------------
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic start_ok;
   logic bit_end;
   logic [7:0] fifo_head;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign fifo_head = fifo_mem[rd_ptr];

   // A push into a full FIFO is dropped even when a pop frees a slot on the
   // same edge, because full is taken from the registered count.
   assign push      = push_req && !full;

   // A flush on this edge suppresses any new frame so the queue ends empty.
   assign start_ok  = enable && !empty && !flush;
   assign bit_end   = (bit_cnt == '0);
   assign pop       = start_ok &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   always_ff @(posedge InputClk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (!push && pop) begin
            count <= count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge InputClk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= DataIn[7:0];
      end
   end

   //---------------------------------------------------------------------------
   // Configuration registers
   //---------------------------------------------------------------------------
   always_ff @(posedge InputClk) begin
      if (rst) begin
         div      <= DIV_RST;
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (div_we) begin
            div <= DataIn[DIV_WIDTH-1:0];
         end
         if (ctrl_we) begin
            enable <= DataIn[0];
         end
         if (clear_ovf) begin
            overflow <= 1'b0;
         end
         if (push_req && full) begin
            overflow <= 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Transmit FSM
   //---------------------------------------------------------------------------
   // The bit counter is reloaded at every bit start with DIV-1, so a bit
   // lasts DIV clocks and a DIV write only affects bits that start later.
   // A stored DIV of 0 loads 0, which gives a one-clock bit.
   logic [DIV_WIDTH-1:0] bit_load;
   assign bit_load = (div == '0) ? '0 : (div - DIV_ONE);

   always_ff @(posedge InputClk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx_out  <= 1'b1;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef MMIO_UART_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state   <= ST_START;
                  tx_out  <= 1'b0;
                  shift   <= fifo_head;
                  bit_cnt <= bit_load;
`ifdef MMIO_UART_PARITY_EN
                  parity  <= ^fifo_head;
`endif
               end
            end

            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  tx_out  <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= '0;
                  bit_cnt <= bit_load;
               end else begin
                  bit_cnt <= bit_cnt - DIV_ONE;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= bit_load;
                  if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                     state  <= ST_PARITY;
                     tx_out <= parity;
`else
                     state  <= ST_STOP;
                     tx_out <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_out  <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  bit_cnt <= bit_cnt - DIV_ONE;
               end
            end

`ifdef MMIO_UART_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state   <= ST_STOP;
                  tx_out  <= 1'b1;
                  bit_cnt <= bit_load;
               end else begin
                  bit_cnt <= bit_cnt - DIV_ONE;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  // Chain straight into the next start bit when data waits.
                  if (pop) begin
                     state   <= ST_START;
                     tx_out  <= 1'b0;
                     shift   <= fifo_head;
                     bit_cnt <= bit_load;
`ifdef MMIO_UART_PARITY_EN
                     parity  <= ^fifo_head;
`endif
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - DIV_ONE;
               end
            end

            default: begin
               state  <= ST_IDLE;
               tx_out <= 1'b1;
            end
         endcase
      end
   end

   assign TxOut  = tx_out;
   assign TxBusy = (state != ST_IDLE);

   //---------------------------------------------------------------------------
   // Read mux
   //---------------------------------------------------------------------------
   logic [31:0] status_word;
   logic [31:0] div_word;
   logic [31:0] read_data;

   always_comb begin
      status_word            = '0;
      status_word[0]         = full;
      status_word[1]         = empty;
      status_word[2]         = TxBusy;
      status_word[3]         = overflow;
      status_word[8 +: CNT_W] = count;

      div_word                = '0;
      div_word[DIV_WIDTH-1:0] = div;

      read_data = '0;
      case (sel)
         SEL_TXDATA: read_data = '0;
         SEL_STATUS: read_data = status_word;
         SEL_DIV:    read_data = div_word;
         SEL_CTRL:   read_data = {31'b0, enable};
         default:    read_data = '0;
      endcase

      DataOut = (Hit && MemReadEn) ? read_data : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
//==============================================================================
// Module   : tb_mmio_uart_tx
// Purpose  : Directed self-checking bench for mmio_uart_tx. Each scenario task
//            drives the bus and compares the serial line, status and register
//            readback against hand-computed values.
// Options  : MMIO_UART_PARITY_EN - adds the parity bit to every expected frame
//            and runs the parity scenario.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam logic [31:0] A_TXDATA = BASE + 32'h0;
   localparam logic [31:0] A_STATUS = BASE + 32'h4;
   localparam logic [31:0] A_DIV    = BASE + 32'h8;
   localparam logic [31:0] A_CTRL   = BASE + 32'hC;
`ifdef MMIO_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd  = 1'b0;
   logic        wr  = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din  = '0;
   logic [31:0] dout;
   logic        hit;
   logic        txo;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   logic line_s [0:511];
   logic busy_s [0:511];

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .DIV_WIDTH  (16),
      .DEFAULT_DIV(16)
   ) dut (
      .InputClk  (clk),
      .rst       (rst),
      .MemReadEn (rd),
      .MemWriteEn(wr),
      .AddressBus(addr),
      .DataIn    (din),
      .DataOut   (dout),
      .Hit       (hit),
      .TxOut     (txo),
      .TxBusy    (busy)
   );

   // Write occupies exactly one rising edge; returns 1 ns after that edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a;
      din  = d;
      wr   = 1'b1;
      @(posedge clk);
      #1;
      wr   = 1'b0;
      addr = '0;
      din  = '0;
   endtask

   // Combinational read in the low phase; no clock edge is consumed.
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      @(negedge clk);
      addr = a;
      rd   = 1'b1;
      #1;
      d    = dout;
      h    = hit;
      rd   = 1'b0;
      addr = '0;
   endtask

   // Sample line and busy 1 ns after each of the next n rising edges.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         line_s[i] = txo;
         busy_s[i] = busy;
      end
   endtask

   function automatic int first_idle(input int n);
      for (int i = 0; i < n; i++) begin
         if (!busy_s[i]) return i;
      end
      return n;
   endfunction

   task automatic test_reset;
      logic [31:0] d;
      logic        h;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (txo !== 1'b1) begin miscompares++; $display("FAIL reset_txout: got %b expected 1", txo); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      #1;
      vectors++;
      if (hit !== 1'b0 || dout !== 32'h0) begin
         miscompares++; $display("FAIL idle_bus: hit %b dout %h expected 0 00000000", hit, dout);
      end
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0002 || h !== 1'b1) begin
         miscompares++; $display("FAIL reset_status: got %h hit %b expected 00000002 hit 1", d, h);
      end
      bus_read(A_DIV, d, h);
      vectors++;
      if (d !== 32'd16) begin miscompares++; $display("FAIL reset_div: got %h expected 00000010", d); end
      bus_read(A_CTRL, d, h);
      vectors++;
      if (d !== 32'd1) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 00000001", d); end
      bus_read(A_TXDATA, d, h);
      vectors++;
      if (d !== 32'd0) begin miscompares++; $display("FAIL txdata_read: got %h expected 00000000", d); end
   endtask

   task automatic test_frame;
      logic [10:0] e;
      int          len;
`ifdef MMIO_UART_PARITY_EN
      e = {1'b1, 1'b0, 8'h55, 1'b0};
`else
      e = {1'b0, 1'b1, 8'h55, 1'b0};
`endif
      bus_write(A_DIV, 32'd4);
      bus_write(A_TXDATA, 32'h55);
      vectors++;
      if (txo !== 1'b1) begin miscompares++; $display("FAIL frame_pre_start: got %b expected 1", txo); end
      capture(NB * 4 + 8);
      for (int i = 0; i < NB * 4; i++) begin
         vectors++;
         if (line_s[i] !== e[i / 4]) begin
            miscompares++;
            $display("FAIL frame_line clk %0d: got %b expected %b", i, line_s[i], e[i / 4]);
         end
      end
      len = first_idle(NB * 4 + 8);
      vectors++;
      if (len !== NB * 4) begin miscompares++; $display("FAIL frame_busy_len: got %0d expected %0d", len, NB * 4); end
      vectors++;
      if (line_s[NB * 4] !== 1'b1) begin miscompares++; $display("FAIL frame_idle_line: got %b expected 1", line_s[NB * 4]); end
   endtask

   task automatic test_overflow_back_to_back;
      logic [31:0] d;
      logic        h;
      logic [7:0]  got;
      int          fl;
      int          len;
      fl = NB * 4;
      bus_write(A_CTRL, 32'h0);
      for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'hA0 + i);
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0809) begin miscompares++; $display("FAIL ovf_status: got %h expected 00000809", d); end
      bus_write(A_CTRL, 32'h5);
      capture(8 * fl + 8);
      len = first_idle(8 * fl + 8);
      vectors++;
      if (len !== 8 * fl) begin miscompares++; $display("FAIL b2b_busy_len: got %0d expected %0d", len, 8 * fl); end
      for (int f = 0; f < 8; f++) begin
         for (int b = 0; b < 8; b++) got[b] = line_s[f * fl + (b + 1) * 4 + 2];
         vectors++;
         if (got !== 8'(8'hA0 + f)) begin
            miscompares++; $display("FAIL b2b_byte %0d: got %h expected %h", f, got, 8'(8'hA0 + f));
         end
         vectors++;
         if (line_s[f * fl + 2] !== 1'b0 || line_s[f * fl + (NB - 1) * 4 + 2] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_framing %0d: start %b stop %b expected 0 1", f,
                     line_s[f * fl + 2], line_s[f * fl + (NB - 1) * 4 + 2]);
         end
      end
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL b2b_status_end: got %h expected 00000002", d); end
      bus_read(A_CTRL, d, h);
      vectors++;
      if (d !== 32'h1) begin miscompares++; $display("FAIL b2b_ctrl: got %h expected 00000001", d); end
   endtask

   task automatic test_flush;
      logic [31:0] d;
      logic        h;
      bus_write(A_CTRL, 32'h0);
      for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 32'h30 + i);
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0300) begin miscompares++; $display("FAIL flush_pre_status: got %h expected 00000300", d); end
      bus_write(A_CTRL, 32'h3);
      capture(4);
      vectors++;
      if (busy_s[0] !== 1'b0 || busy_s[3] !== 1'b0) begin
         miscompares++; $display("FAIL flush_busy: got %b%b expected 00", busy_s[0], busy_s[3]);
      end
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL flush_status: got %h expected 00000002", d); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] d;
      logic        h;
      bus_write(A_TXDATA, 32'h34);
      bus_write(A_TXDATA, 32'h99);
      repeat (17) @(posedge clk);
      #1;
      vectors++;
      if (txo !== 1'b0 || busy !== 1'b1) begin
         miscompares++; $display("FAIL mid_data_bit3: txout %b busy %b expected 0 1", txo, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (txo !== 1'b1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL mid_reset: txout %b busy %b expected 1 0", txo, busy);
      end
      rst = 1'b0;
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL mid_reset_status: got %h expected 00000002", d); end
      bus_read(A_DIV, d, h);
      vectors++;
      if (d !== 32'd16) begin miscompares++; $display("FAIL mid_reset_div: got %h expected 00000010", d); end
   endtask

   task automatic test_window;
      logic [31:0] d;
      logic        h;
      bus_read(BASE + 32'h14, d, h);
      vectors++;
      if (h !== 1'b0 || d !== 32'h0) begin miscompares++; $display("FAIL win_above: hit %b data %h expected 0 00000000", h, d); end
      bus_read(BASE - 32'hC, d, h);
      vectors++;
      if (h !== 1'b0 || d !== 32'h0) begin miscompares++; $display("FAIL win_below: hit %b data %h expected 0 00000000", h, d); end
      bus_write(BASE + 32'h10, 32'h41);
      bus_write(BASE + 32'h18, 32'h7);
      bus_write(BASE + 32'h1C, 32'h0);
      capture(3);
      vectors++;
      if (busy_s[2] !== 1'b0) begin miscompares++; $display("FAIL win_busy: got %b expected 0", busy_s[2]); end
      bus_read(A_STATUS, d, h);
      vectors++;
      if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL win_status: got %h expected 00000002", d); end
      bus_read(A_DIV, d, h);
      vectors++;
      if (d !== 32'd16) begin miscompares++; $display("FAIL win_div: got %h expected 00000010", d); end
      bus_read(A_CTRL, d, h);
      vectors++;
      if (d !== 32'd1) begin miscompares++; $display("FAIL win_ctrl: got %h expected 00000001", d); end
      @(negedge clk);
      addr = A_STATUS;
      #1;
      vectors++;
      if (hit !== 1'b0) begin miscompares++; $display("FAIL win_no_strobe: hit %b expected 0", hit); end
      addr = '0;
   endtask

   task automatic test_div_zero;
      logic [10:0] e;
      int          len;
`ifdef MMIO_UART_PARITY_EN
      e = {1'b1, 1'b0, 8'h0F, 1'b0};
`else
      e = {1'b0, 1'b1, 8'h0F, 1'b0};
`endif
      bus_write(A_DIV, 32'h0);
      bus_write(A_TXDATA, 32'h0F);
      capture(NB + 4);
      for (int i = 0; i < NB; i++) begin
         vectors++;
         if (line_s[i] !== e[i]) begin
            miscompares++; $display("FAIL div0_line clk %0d: got %b expected %b", i, line_s[i], e[i]);
         end
      end
      len = first_idle(NB + 4);
      vectors++;
      if (len !== NB) begin miscompares++; $display("FAIL div0_busy_len: got %0d expected %0d", len, NB); end
   endtask

`ifdef MMIO_UART_PARITY_EN
   task automatic test_parity;
      logic [10:0] e;
      int          len;
      e = {1'b1, 1'b1, 8'h07, 1'b0};
      bus_write(A_DIV, 32'd4);
      bus_write(A_TXDATA, 32'h07);
      capture(52);
      for (int i = 0; i < 44; i++) begin
         vectors++;
         if (line_s[i] !== e[i / 4]) begin
            miscompares++; $display("FAIL parity_line clk %0d: got %b expected %b", i, line_s[i], e[i / 4]);
         end
      end
      len = first_idle(52);
      vectors++;
      if (len !== 44) begin miscompares++; $display("FAIL parity_busy_len: got %0d expected 44", len); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_overflow_back_to_back();
      test_flush();
      test_reset_midframe();
      test_window();
      test_div_zero();
`ifdef MMIO_UART_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmitter that responds on the CPU data bus alongside `DataMemory`. It decodes accesses to its register window, accepts bytes written by the CPU into a transmit FIFO, and serialises them as 8N1 frames on a single output line. Register reads return status and configuration. The block is the responder end of the CPU's `AddressBus` / `ControlBus` / data-bus protocol. It lets programs under simulation emit characters without touching `DataMemory`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: register window base; 16-byte aligned.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; power of 2, at least 2.
- `DIV_WIDTH`, default 16: width of the divisor register.
- `DEFAULT_DIV`, default 16: divisor reset value, in clocks per bit.

- `InputClk`, in, 1: clock. The top level drives the same inverted CPU clock that `DataMemory` receives.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `MemReadEn`, in, 1: `ControlBus[1]`.
- `MemWriteEn`, in, 1: `ControlBus[2]`.
- `AddressBus`, in, 32: byte address from the CPU.
- `DataIn`, in, 32: write data (CPU `DataBusOut`).
- `DataOut`, out, 32: read data. It is 0 unless `Hit` and `MemReadEn` are both high.
- `Hit`, out, 1: combinational. Asserted when `AddressBus[31:4]==BASE_ADDR[31:4]` and (`MemReadEn` | `MemWriteEn`). The top level uses it to mux `DataBusIn` and to gate the `DataMemory` write enable.
- `TxOut`, out, 1: serial line; idles high.
- `TxBusy`, out, 1: high while a frame is being shifted.

## Operation
- Register select is `AddressBus[3:2]`. `AddressBus[1:0]` is ignored.
- Offset 0x0, TXDATA:
  - Write pushes `DataIn[7:0]` into the FIFO.
  - Read returns 0.
- Offset 0x4, STATUS (read-only; writes ignored):
  - bit0 = full, bit1 = empty, bit2 = `TxBusy`, bit3 = sticky overflow.
  - bits[15:8] = FIFO count.
  - All other bits are 0.
- Offset 0x8, DIV: read/write, bits[DIV_WIDTH-1:0]. A written value of 0 behaves as 1.
- Offset 0xC, CTRL:
  - bit0 = enable; reset value 1.
  - Writing bit1=1 flushes the FIFO; the bit self-clears and reads as 0.
  - Writing bit2=1 clears overflow; the bit self-clears and reads as 0.
- Write to TXDATA while full: the byte is dropped and overflow is set. This holds even if a pop happens in the same cycle.
- Transmit FSM, states and transitions:
  - IDLE → START when enable=1 and the FIFO is not empty. The transition pops one byte into the shift register.
  - START: `TxOut`=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - (PARITY: only when configured; see Configuration.)
  - STOP: `TxOut`=1 for one bit period, then return to IDLE.
- Bit period = DIV clocks, counted by a down-counter that is loaded at each bit start. A DIV change takes effect at the next bit start.
- Enable cleared mid-frame: the current frame completes, and no new frame starts.
- FIFO flush mid-frame: the current frame completes and the queued bytes are discarded. A flush in the same cycle as a push wins: the FIFO ends empty.
- `TxBusy` = FSM not in IDLE.

## Timing
- Reset values after a `rst` edge:
  - `TxOut`=1, `TxBusy`=0, FSM=IDLE.
  - FIFO empty, count 0, overflow 0.
  - DIV=`DEFAULT_DIV`, enable=1.
  - `DataOut` and `Hit` are combinational; they are 0 when the bus is idle.
- Reset asserted mid-frame aborts the frame. `TxOut` returns to 1 on that edge.
- Register writes take effect on the rising `InputClk` edge with `MemWriteEn` & `Hit`.
- Reads are combinational. They reflect state as of the last edge.
- Latency:
  - A TXDATA write at edge N makes count 1 after N.
  - With the FSM idle, the byte pops at edge N+1, and `TxOut` falls after edge N+1.
  - Frame length is 10×DIV clocks; 11×DIV with parity.
- Back-to-back frames: when STOP completes and the FIFO is non-empty, the FSM moves STOP→START directly with no idle gap.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.

## Configuration
- `MMIO_UART_PARITY_EN`:
  - Defined: a PARITY state follows DATA and sends the even-parity bit (XOR of the 8 data bits) for one bit period. Frame is 11 bit periods.
  - Undefined: no parity state; 8N1 frames of 10 bit periods.

## Test plan
- Reset, then read STATUS: returns 0x0000_0002. DIV reads 16; CTRL reads 1; `TxOut`=1.
- Write DIV=4, then TXDATA=0x55: `TxOut` goes low 1 edge after the write. The line then shows 0,1,0,1,0,1,0,1,0,1 in 4-clock bits, and `TxBusy` falls 40 clocks after the frame starts.
- With enable=0, write 9 bytes at `FIFO_DEPTH`=8: STATUS shows full, count 8, overflow=1. Writing CTRL=0x5 keeps enable=1 and clears overflow; 8 frames are then emitted back-to-back with no idle clocks between them.
- Reset asserted during DATA bit 3: `TxOut`=1 and `TxBusy`=0 after the edge, and the FIFO is empty.
- Access an address outside the window (BASE_ADDR+0x10): `Hit`=0 and `DataOut`=0, with no state change. With `MMIO_UART_PARITY_EN` defined, byte 0x07 produces parity bit 1 and an 11-bit frame.
